// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI slave (spi_slave_iw).
// Build option: define SPI_SLAVE_TX_EN to enable the miso transmit path.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with registered rise/fall pulse outputs.
// RST_VAL sets the idle level the chain resets to.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_iw.sv
// SPI mode-0 slave, oversampled in the clk domain; byte-wide receive.
// Define SPI_SLAVE_TX_EN to return tx_data on miso; otherwise miso is 0.
module spi_slave_iw
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [BYTE_W-1:0] tx_data,
  output logic [BYTE_W-1:0] dout_iw,
  output logic              done_iw,
  output logic              busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] rx_q, rx_d, rx_next;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              wrap;

  assign wrap = (state_q == SHIFT) && !cs_s && sclk_rise
             && (cnt_q == CNT_W'(BYTE_W - 1));

  always_comb begin
    if (MSB_FIRST != 0) rx_next = {rx_q[BYTE_W-2:0], mosi_s};
    else                rx_next = {mosi_s, rx_q[BYTE_W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        rx_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // level check also catches a cs_n rise that landed during LOAD
        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          rx_d    = '0;
        end else if (sclk_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (wrap) begin
            dout_d = rx_next;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic              tx_bit, load_bit;

  always_comb begin
    tx_d = tx_q;
    if (state_q == LOAD || wrap) begin
      tx_d = tx_data;
    // the fall right after a wrap must keep the freshly loaded first bit
    end else if (state_q == SHIFT && !cs_s && sclk_fall && cnt_q != '0) begin
      if (MSB_FIRST != 0) tx_d = {tx_q[BYTE_W-2:0], 1'b0};
      else                tx_d = {1'b0, tx_q[BYTE_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_q <= '0;
    else     tx_q <= tx_d;
  end

  always_comb begin
    tx_bit   = (MSB_FIRST != 0) ? tx_q[BYTE_W-1] : tx_q[0];
    load_bit = (MSB_FIRST != 0) ? tx_data[BYTE_W-1] : tx_data[0];
    miso     = 1'b0;
    if (state_q == LOAD)       miso = load_bit;
    else if (state_q == SHIFT) miso = tx_bit;
  end

  logic unused_ok;
  assign unused_ok = ^{sclk_s, cs_rise, mosi_rise, mosi_fall};
`else
  assign miso = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{sclk_s, cs_rise, mosi_rise, mosi_fall, tx_data};
`endif

  assign dout_iw = dout_q;
  assign done_iw = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_iw.sv
// Directed bench for spi_slave_iw: MSB-first and LSB-first instances
// share the SPI wires; received bytes are checked through scoreboards.
module tb_spi_slave_iw;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       miso_m, done_m, busy_m;
  logic [7:0] dout_m;
  logic       miso_l, done_l, busy_l;
  logic [7:0] dout_l;

  spi_slave_iw #(.SYNC_STAGES(2), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_m), .tx_data(tx_data), .dout_iw(dout_m),
    .done_iw(done_m), .busy(busy_m)
  );

  spi_slave_iw #(.SYNC_STAGES(3), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_l), .tx_data(tx_data), .dout_iw(dout_l),
    .done_iw(done_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int pushed  = 0;
  int nd_m    = 0;
  int nd_l    = 0;
  logic pd_m  = 1'b0;
  logic pd_l  = 1'b0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [7:0] tx_exp(input logic [7:0] b);
`ifdef SPI_SLAVE_TX_EN
    return b;
`else
    return 8'h00 & b;
`endif
  endfunction

  always @(negedge clk) begin
    if (done_m) begin
      nd_m++;
      chk("done_width_m", {31'd0, pd_m}, 0);
      chk("sb_nonempty_m", {31'd0, q_m.size() > 0}, 1);
      if (q_m.size() > 0) chk("dout_m", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
    end
    if (done_l) begin
      nd_l++;
      chk("done_width_l", {31'd0, pd_l}, 0);
      chk("sb_nonempty_l", {31'd0, q_l.size() > 0}, 1);
      if (q_l.size() > 0) chk("dout_l", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
    end
    pd_m = done_m;
    pd_l = done_l;
  end

  task automatic expect_byte(input logic [7:0] wire_b);
    q_m.push_back(wire_b);
    q_l.push_back(rev8(wire_b));
    pushed++;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #40;
    cs_n = 1'b1;
    #200;
  endtask

  // wire order is always MSB of b first; miso captured in wire order
  task automatic xfer(input logic [7:0] b, input int nbits,
                      output logic [7:0] mi_m, output logic [7:0] mi_l);
    mi_m = 8'h00;
    mi_l = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #40;
      mi_m = {mi_m[6:0], miso_m};
      mi_l = {mi_l[6:0], miso_l};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mm, ml;
    int nd0;

    #33;
    chk("rst_dout_m", {24'd0, dout_m}, 0);
    chk("rst_dout_l", {24'd0, dout_l}, 0);
    chk("rst_done",   {30'd0, done_m, done_l}, 0);
    chk("rst_miso",   {30'd0, miso_m, miso_l}, 0);
    chk("rst_busy",   {30'd0, busy_m, busy_l}, 0);
    rst = 1'b0;
    #40;

    // loopback of 3C while receiving 00
    tx_data = 8'h3C;
    #20;
    cs_low();
    chk("busy_frame", {30'd0, busy_m, busy_l}, 3);
    expect_byte(8'h00);
    xfer(8'h00, 8, mm, ml);
    cs_high();
    chk("loop_miso_m", {24'd0, mm}, {24'd0, tx_exp(8'h3C)});
    chk("loop_miso_l", {24'd0, ml}, {24'd0, tx_exp(rev8(8'h3C))});
    chk("busy_idle", {30'd0, busy_m, busy_l}, 0);
    chk("miso_idle", {30'd0, miso_m, miso_l}, 0);

    // single byte A5
    tx_data = 8'hC3;
    cs_low();
    expect_byte(8'hA5);
    xfer(8'hA5, 8, mm, ml);
    cs_high();
    chk("a5_miso_m", {24'd0, mm}, {24'd0, tx_exp(8'hC3)});
    chk("a5_hold_m", {24'd0, dout_m}, 8'hA5);

    // two bytes in one frame, tx_data changed before the wrap
    tx_data = 8'h55;
    cs_low();
    tx_data = 8'h81;
    expect_byte(8'h01);
    xfer(8'h01, 8, mm, ml);
    chk("b1_miso_m", {24'd0, mm}, {24'd0, tx_exp(8'h55)});
    chk("b1_miso_l", {24'd0, ml}, {24'd0, tx_exp(rev8(8'h55))});
    expect_byte(8'hFE);
    xfer(8'hFE, 8, mm, ml);
    chk("b2_miso_m", {24'd0, mm}, {24'd0, tx_exp(8'h81)});
    chk("b2_miso_l", {24'd0, ml}, {24'd0, tx_exp(rev8(8'h81))});
    cs_high();

    // abort after 5 bits
    nd0 = nd_m + nd_l;
    cs_low();
    xfer(8'hFF, 5, mm, ml);
    cs_high();
    chk("abort_no_done", nd_m + nd_l, nd0);
    chk("abort_hold_m", {24'd0, dout_m}, 8'hFE);
    chk("abort_hold_l", {24'd0, dout_l}, 8'h7F);
    cs_low();
    expect_byte(8'h12);
    xfer(8'h12, 8, mm, ml);
    cs_high();

    // reset after 4 bits
    nd0 = nd_m + nd_l;
    cs_low();
    xfer(8'hF0, 4, mm, ml);
    #20;
    rst = 1'b1;
    #1;
    chk("mrst_dout", {16'd0, dout_m, dout_l}, 0);
    chk("mrst_outs", {26'd0, done_m, done_l, miso_m, miso_l, busy_m, busy_l}, 0);
    cs_n = 1'b1;
    #60;
    rst = 1'b0;
    #100;
    chk("mrst_no_done", nd_m + nd_l, nd0);
    chk("mrst_idle", {30'd0, busy_m, busy_l}, 0);
    cs_low();
    expect_byte(8'h77);
    xfer(8'h77, 8, mm, ml);
    cs_high();

    // stream 1,0,0,0,0,0,0,0: LSB-first instance sees 01
    cs_low();
    expect_byte(8'h80);
    xfer(8'h80, 8, mm, ml);
    cs_high();
    chk("lsb_dout", {24'd0, dout_l}, 8'h01);

    #100;
    chk("done_count_m", nd_m, pushed);
    chk("done_count_l", nd_l, pushed);
    chk("sb_drained", q_m.size() + q_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_iw.md
SPI_SLAVE_IW -- requirements
Module: spi_slave_iw

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the sclk/cs_n/mosi synchronizers (legal 2..3).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning bit order on the wire (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 SHALL have port mosi  input  1  SPI serial data in, asynchronous.
REQ-008 SHALL have port miso  output  1  SPI serial data out.
REQ-009 SHALL have port tx_data  input  8  byte to return to the master (the grid's dout).
REQ-010 SHALL have port dout_iw  output  8  last complete received byte.
REQ-011 SHALL have port done_iw  output  1  one-clk pulse marking a new dout_iw.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress (synchronized cs_n low).

Function
REQ-013 SHALL pass sclk, cs_n and mosi through SYNC_STAGES-deep synchronizers; all edge detection uses the synchronized signals.
REQ-014 SHALL require clk >= 4x sclk; behaviour at slower clk ratios is undefined.
REQ-015 SHALL implement FSM states IDLE (cs_n high), LOAD (one cycle after the cs_n falling edge), SHIFT (cs_n low).
REQ-016 IDLE->LOAD on the synchronized cs_n falling edge; LOAD->SHIFT unconditionally; SHIFT->IDLE on the synchronized cs_n rising edge.
REQ-017 In LOAD, SHALL capture tx_data into the tx shift register and clear the 3-bit bit counter.
REQ-018 In SHIFT, on each synchronized sclk rising edge, SHALL shift mosi into the rx shift register per MSB_FIRST and increment the bit counter.
REQ-019 On the rising edge that brings the bit counter from 7 to 0 (wrap), SHALL copy the assembled byte to dout_iw and assert done_iw for exactly one clk cycle, 1 clk after the synchronized edge.
REQ-020 On the same wrap cycle, SHALL reload the tx shift register from the current tx_data, so multi-byte frames need no cs_n toggle.
REQ-021 On each synchronized sclk falling edge in SHIFT, SHALL shift the tx register so miso presents the next bit; the first bit is valid on miso from LOAD onward.
REQ-022 cs_n rising mid-byte (counter != 0) SHALL abort: partial byte discarded, no done_iw, dout_iw unchanged, counter cleared.
REQ-023 sclk edges while synchronized cs_n is high SHALL be ignored.
REQ-024 dout_iw SHALL hold its value between done_iw pulses.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 miso SHALL drive 0 in IDLE.

Reset
REQ-027 While rst is high: state IDLE, dout_iw = 8'h00, done_iw = 0, miso = 0, busy = 0, bit counter = 0, shift registers = 0, synchronizer flops set to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-028 rst asserted mid-frame SHALL abort with no done_iw; after release the block SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_TX_EN: when defined, miso transmits tx_data as in REQ-017/020/021.
REQ-030 When SPI_SLAVE_TX_EN is undefined, the tx shift register SHALL be omitted, miso SHALL be constant 0, and tx_data is unused; receive behaviour is unchanged.

Structure
REQ-031 SHALL place the FSM state enum (IDLE/LOAD/SHIFT), byte width 8 and bit-counter width 3 in shared package spi_pkg.
REQ-032 SHALL use one sub-module, sync_edge, instantiated per input: synchronizer plus rise/fall pulse outputs.

Verification
REQ-033 Single byte: cs_n low, send 8'hA5 MSB-first at clk/8, cs_n high -> one done_iw pulse, dout_iw = 8'hA5.
REQ-034 Loopback: tx_data = 8'h3C before cs_n falls, send 8'h00 -> miso sequence 0,0,1,1,1,1,0,0; with macro undefined -> miso all 0.
REQ-035 Two bytes, one frame: send 8'h01 then 8'hFE without raising cs_n -> two done_iw pulses, dout_iw 8'h01 then 8'hFE; tx_data changed to 8'h81 before the wrap -> second miso byte is 8'h81.
REQ-036 Abort: cs_n high after 5 bits of 8'hFF -> no done_iw, dout_iw keeps its prior value; next full byte 8'h12 -> dout_iw = 8'h12.
REQ-037 Reset mid-byte: rst pulse after 4 bits -> all outputs 0 immediately; subsequent frame 8'h77 -> dout_iw = 8'h77.
REQ-038 MSB_FIRST = 0: send bit stream 1,0,0,0,0,0,0,0 -> dout_iw = 8'h01.
